vga_timing_gen: RTL and testbench



---
 rtl/vga_pkg.sv | 37 +++
 rtl/vga_axis_cnt.sv | 33 +++
 rtl/vga_timing_gen.sv | 143 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants for the VGA raster generator: 640x480@60 default timing,
// capture-window mode encoding and the mode-to-shift mapping.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;

    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam bit DEF_HS_POL   = 1'b0;
    localparam bit DEF_VS_POL   = 1'b0;

    localparam int DEF_CW       = 10;
    localparam int DEF_AW       = 19;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_FULL    = 2'd0;
    localparam mode_t MODE_HALF    = 2'd1;
    localparam mode_t MODE_QUARTER = 2'd2;

    // Mode 3 has no window of its own and falls back to the quarter window.
    function automatic logic [1:0] mode_shift(input mode_t m);
        case (m)
            MODE_FULL:    return 2'd0;
            MODE_HALF:    return 2'd1;
            MODE_QUARTER: return 2'd2;
            default:      return 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// One raster axis: wrapping position counter with step enable, terminal-count
// flag and a combinational sync-window compare.
module vga_axis_cnt #(
    parameter int TOTAL      = 800,
    parameter int SYNC_START = 656,
    parameter int SYNC_LEN   = 96,
    parameter bit POL        = 1'b0,
    parameter int CW         = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          step,
    output logic [CW-1:0] cnt,
    output logic          tc,
    output logic          sync
);

    localparam logic [CW-1:0] LAST    = CW'(TOTAL - 1);
    localparam logic [CW-1:0] SYNC_LO = CW'(SYNC_START);
    localparam logic [CW-1:0] SYNC_HI = CW'(SYNC_START + SYNC_LEN - 1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= tc ? '0 : cnt + CW'(1);
        end
    end

    assign tc   = (cnt == LAST);
    assign sync = ((cnt >= SYNC_LO) && (cnt <= SYNC_HI)) ? POL : ~POL;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: sync/blank for the DAC, a
// mode-selectable capture window with coordinates and a linear read address.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = DEF_HS_POL,
    parameter bit VS_POL   = DEF_VS_POL,
    parameter int CW       = DEF_CW,
    parameter int AW       = DEF_AW
) (
    input  logic          CLK25,
    input  logic          Nreset,
    input  logic          en,
    input  logic [1:0]    mode,
    output logic          clkout,
    output logic          Hsync,
    output logic          Vsync,
    output logic          Nblank,
    output logic          Nsync,
    output logic          activeArea,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic [AW-1:0] pix_addr,
    output logic          frame_start,
    output logic          line_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_ACT = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT = CW'(V_ACTIVE);

    logic [CW-1:0] hcnt;
    logic [CW-1:0] vcnt;
    logic          h_tc;
    logic          v_tc;
    logic          h_sync;
    logic          v_sync;

    mode_t         mode_sh;
    logic [1:0]    shift;
    logic [CW-1:0] win_h;
    logic [CW-1:0] win_v;
    logic          in_window;
    logic          in_active;
    logic          at_frame;
    logic          at_line;

    vga_axis_cnt #(
        .TOTAL      (H_TOTAL),
        .SYNC_START (H_ACTIVE + H_FP),
        .SYNC_LEN   (H_SYNC),
        .POL        (HS_POL),
        .CW         (CW)
    ) u_h_cnt (
        .clk   (CLK25),
        .rst_n (Nreset),
        .step  (en),
        .cnt   (hcnt),
        .tc    (h_tc),
        .sync  (h_sync)
    );

    vga_axis_cnt #(
        .TOTAL      (V_TOTAL),
        .SYNC_START (V_ACTIVE + V_FP),
        .SYNC_LEN   (V_SYNC),
        .POL        (VS_POL),
        .CW         (CW)
    ) u_v_cnt (
        .clk   (CLK25),
        .rst_n (Nreset),
        .step  (en && h_tc),
        .cnt   (vcnt),
        .tc    (v_tc),
        .sync  (v_sync)
    );

    // Mode is only picked up on the very last pixel so a frame never changes window mid-scan.
    always_ff @(posedge CLK25) begin
        if (!Nreset) begin
            mode_sh <= mode;
        end else if (en && h_tc && v_tc) begin
            mode_sh <= mode;
        end
    end

    always_comb begin
        shift     = mode_shift(mode_sh);
        win_h     = CW'(H_ACTIVE >> shift);
        win_v     = CW'(V_ACTIVE >> shift);
        in_window = (hcnt < win_h) && (vcnt < win_v);
        in_active = (hcnt < H_ACT) && (vcnt < V_ACT);
        at_line   = (hcnt == '0);
        at_frame  = at_line && (vcnt == '0);
    end

    // Every pin is a registered decode of the counter position it was loaded from,
    // so the whole group shares one cycle of latency.
    always_ff @(posedge CLK25) begin
        if (!Nreset) begin
            Hsync       <= ~HS_POL;
            Vsync       <= ~VS_POL;
            Nblank      <= 1'b0;
            activeArea  <= 1'b0;
            x           <= '0;
            y           <= '0;
            pix_addr    <= '0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else if (en) begin
            Hsync       <= h_sync;
            Vsync       <= v_sync;
            Nblank      <= in_active;
            activeArea  <= in_window;
            frame_start <= at_frame;
            line_start  <= at_line;
            if (in_window) begin
                x <= hcnt;
                y <= vcnt;
            end
            // The address advances after each presented window pixel instead of being computed as y*WH+x.
            if (at_frame) begin
                pix_addr <= '0;
            end else if (activeArea) begin
                pix_addr <= pix_addr + AW'(1);
            end
        end
    end

    assign clkout = CLK25;
    assign Nsync  = 1'b1;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a tiny 14x7 raster, compared cycle
// by cycle against a position-arithmetic reference model.
module tb_vga_timing_gen;

    localparam int HA  = 8;
    localparam int HF  = 2;
    localparam int HSW = 2;
    localparam int HB  = 2;
    localparam int VA  = 4;
    localparam int VF  = 1;
    localparam int VSW = 1;
    localparam int VB  = 1;
    localparam bit HS_POL = 1'b1;
    localparam bit VS_POL = 1'b0;
    localparam int CW  = 4;
    localparam int AW  = 5;
    localparam int HT  = HA + HF + HSW + HB;
    localparam int VT  = VA + VF + VSW + VB;
    localparam int FT  = HT * VT;

    logic          CLK25 = 1'b0;
    logic          Nreset = 1'b0;
    logic          en = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic          clkout;
    logic          Hsync;
    logic          Vsync;
    logic          Nblank;
    logic          Nsync;
    logic          activeArea;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [AW-1:0] pix_addr;
    logic          frame_start;
    logic          line_start;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state: raster position index within the frame and the frame's mode.
    int         k = 0;
    logic [1:0] cur_mode = 2'd0;
    logic       e_hs = 1'b0;
    logic       e_vs = 1'b0;
    logic       e_nb = 1'b0;
    logic       e_act = 1'b0;
    int         e_x = 0;
    int         e_y = 0;
    int         e_pa = 0;
    logic       e_pa_valid = 1'b0;
    logic       e_fs = 1'b0;
    logic       e_ls = 1'b0;

    vga_timing_gen #(
        .H_ACTIVE (HA),
        .H_FP     (HF),
        .H_SYNC   (HSW),
        .H_BP     (HB),
        .V_ACTIVE (VA),
        .V_FP     (VF),
        .V_SYNC   (VSW),
        .V_BP     (VB),
        .HS_POL   (HS_POL),
        .VS_POL   (VS_POL),
        .CW       (CW),
        .AW       (AW)
    ) dut (
        .CLK25       (CLK25),
        .Nreset      (Nreset),
        .en          (en),
        .mode        (mode),
        .clkout      (clkout),
        .Hsync       (Hsync),
        .Vsync       (Vsync),
        .Nblank      (Nblank),
        .Nsync       (Nsync),
        .activeArea  (activeArea),
        .x           (x),
        .y           (y),
        .pix_addr    (pix_addr),
        .frame_start (frame_start),
        .line_start  (line_start)
    );

    always #20 CLK25 = ~CLK25;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic checkOutput();
        cmp("hsync", 32'(Hsync), 32'(e_hs));
        cmp("vsync", 32'(Vsync), 32'(e_vs));
        cmp("nblank", 32'(Nblank), 32'(e_nb));
        cmp("active_area", 32'(activeArea), 32'(e_act));
        cmp("x", 32'(x), e_x);
        cmp("y", 32'(y), e_y);
        cmp("frame_start", 32'(frame_start), 32'(e_fs));
        cmp("line_start", 32'(line_start), 32'(e_ls));
        cmp("nsync", 32'(Nsync), 32'd1);
        cmp("clkout", 32'(clkout), 32'(CLK25));
        if (e_pa_valid) cmp("pix_addr", 32'(pix_addr), e_pa);
    endtask

    // Drive one cycle of inputs, predict the registered outputs, then check them mid-cycle.
    task automatic applyStimulus(input bit rst_n_i, input bit en_i, input logic [1:0] mode_i);
        int h, v, s, wh, wv;
        Nreset = rst_n_i;
        en     = en_i;
        mode   = mode_i;
        if (!rst_n_i) begin
            k          = 0;
            cur_mode   = mode_i;
            e_hs       = !HS_POL;
            e_vs       = !VS_POL;
            e_nb       = 1'b0;
            e_act      = 1'b0;
            e_x        = 0;
            e_y        = 0;
            e_pa       = 0;
            e_pa_valid = 1'b1;
            e_fs       = 1'b0;
            e_ls       = 1'b0;
        end else if (en_i) begin
            h  = k % HT;
            v  = k / HT;
            s  = (cur_mode == 2'd0) ? 0 : (cur_mode == 2'd1) ? 1 : 2;
            wh = HA >> s;
            wv = VA >> s;
            e_hs  = (h >= HA + HF && h < HA + HF + HSW) ? HS_POL : !HS_POL;
            e_vs  = (v >= VA + VF && v < VA + VF + VSW) ? VS_POL : !VS_POL;
            e_nb  = (h < HA) && (v < VA);
            e_act = (h < wh) && (v < wv);
            if (e_act) begin
                e_x = h;
                e_y = v;
            end
            e_pa       = v * wh + h;
            e_pa_valid = e_act;
            e_fs       = (k == 0);
            e_ls       = (h == 0);
            if (k == FT - 1) cur_mode = mode_i;
            k = (k + 1) % FT;
        end
        @(posedge CLK25);
        @(negedge CLK25);
        checkOutput();
    endtask

    initial begin
        int nb_cnt, hs_cnt, vs_cnt, fs_cnt, act_cnt, last_pa;
        int tgt;

        $display("[TB] reset with en high and low");
        applyStimulus(1'b0, 1'b1, 2'd0);
        applyStimulus(1'b0, 1'b0, 2'd0);

        $display("[TB] full mode, one frame of aggregate timing");
        nb_cnt = 0; hs_cnt = 0; vs_cnt = 0; fs_cnt = 0;
        for (int i = 0; i < FT; i++) begin
            applyStimulus(1'b1, 1'b1, 2'd0);
            if (i == 0) begin
                cmp("first_frame_start", 32'(frame_start), 32'd1);
                cmp("first_pix_addr", 32'(pix_addr), 32'd0);
            end
            nb_cnt += int'(Nblank);
            hs_cnt += int'(Hsync == HS_POL);
            vs_cnt += int'(Vsync == VS_POL);
            fs_cnt += int'(frame_start);
        end
        cmp("nblank_cycles", nb_cnt, HA * VA);
        cmp("hsync_cycles", hs_cnt, HSW * VT);
        cmp("vsync_cycles", vs_cnt, VSW * HT);
        cmp("frame_starts", fs_cnt, 1);

        $display("[TB] request quarter window, takes effect next frame");
        act_cnt = 0;
        for (int i = 0; i < FT; i++) begin
            applyStimulus(1'b1, 1'b1, 2'd2);
            act_cnt += int'(activeArea);
        end
        cmp("window_before_switch", act_cnt, HA * VA);
        act_cnt = 0; last_pa = -1;
        for (int i = 0; i < FT; i++) begin
            applyStimulus(1'b1, 1'b1, 2'd2);
            act_cnt += int'(activeArea);
            if (activeArea) last_pa = int'(pix_addr);
        end
        cmp("quarter_window", act_cnt, (HA / 4) * (VA / 4));
        cmp("quarter_last_addr", last_pa, (HA / 4) * (VA / 4) - 1);

        $display("[TB] mode 0 then switch to 1 mid-frame");
        for (int i = 0; i < FT; i++) applyStimulus(1'b1, 1'b1, 2'd0);
        act_cnt = 0;
        for (int i = 0; i < FT; i++) begin
            applyStimulus(1'b1, 1'b1, (i < 2 * HT) ? 2'd0 : 2'd1);
            act_cnt += int'(activeArea);
        end
        cmp("full_kept_after_switch", act_cnt, HA * VA);
        act_cnt = 0; last_pa = -1;
        for (int i = 0; i < FT; i++) begin
            applyStimulus(1'b1, 1'b1, 2'd1);
            act_cnt += int'(activeArea);
            if (activeArea) last_pa = int'(pix_addr);
        end
        cmp("half_window", act_cnt, (HA / 2) * (VA / 2));
        cmp("half_last_addr", last_pa, (HA / 2) * (VA / 2) - 1);

        $display("[TB] random enable and mode");
        for (int i = 0; i < 700; i++) begin
            applyStimulus(1'b1, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)));
        end

        $display("[TB] reset pulse mid-frame");
        tgt = 3 * HT + 5;
        for (int i = 0; i < FT && k != tgt; i++) applyStimulus(1'b1, 1'b1, 2'd0);
        cmp("reached_reset_point", k, tgt);
        applyStimulus(1'b0, 1'b1, 2'd1);
        applyStimulus(1'b0, 1'b0, 2'd1);
        act_cnt = 0;
        for (int i = 0; i < FT; i++) begin
            applyStimulus(1'b1, 1'b1, 2'd1);
            if (i == 0) cmp("post_reset_frame_start", 32'(frame_start), 32'd1);
            act_cnt += int'(activeArea);
        end
        cmp("post_reset_half_window", act_cnt, (HA / 2) * (VA / 2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
